// File: rtl/ipv4_header_gen.sv
// ipv4_header_gen: builds a 20-byte IPv4 header, runs a byte-serial checksum pass, then streams it out.
// Optional IPV4_HDR_IDENT_INC_EN: ident counts completed headers instead of staying 0.
module ipv4_header_gen #(
    parameter int         BYTE_LEN = 8,
    parameter logic [7:0] TTL      = 8'd64,
    parameter logic [7:0] PROTO    = 8'd17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [31:0]         src_ip,
    input  logic [31:0]         dst_ip,
    input  logic [15:0]         payload_len,
    output logic                busy,
    output logic                err,
    output logic [BYTE_LEN-1:0] out,
    output logic                outclk,
    input  logic                outready,
    output logic                done
);
    typedef enum logic [1:0] {IDLE, SUM, LATCH, SEND} state_t;
    state_t state, state_nxt;
    logic [4:0] idx;
    logic [31:0] src_q, dst_q;
    logic [15:0] len_q, sum_q, sum_nxt, csum_q, ident;
    logic [159:0] hdr;
    logic [7:0] bit_hi, byte_cur;
    logic [16:0] acc;
    logic accept, reject, xfer, fin;
    assign accept = (state == IDLE) && start && (payload_len <= 16'd65515);
    assign reject = (state == IDLE) && start && (payload_len > 16'd65515);
    assign xfer   = (state == SEND) && outready;
    assign fin    = xfer && (idx == 5'd19);
    // checksum field reads as zero during the SUM pass
    assign hdr = {8'h45, 8'h00, len_q, ident, 8'h40, 8'h00, TTL, PROTO,
                  (state == SEND) ? csum_q : 16'h0000, src_q, dst_q};
    assign bit_hi   = 8'd159 - {idx, 3'b000};
    assign byte_cur = hdr[bit_hi -: 8];
    assign acc      = {1'b0, sum_q} + {1'b0, idx[0] ? {8'h00, byte_cur} : {byte_cur, 8'h00}};
    assign sum_nxt  = acc[15:0] + {15'b0, acc[16]};
    assign busy     = state != IDLE;
    assign outclk   = state == SEND;
    assign out      = (state == SEND) ? byte_cur : '0;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? SUM : IDLE;
            SUM:     state_nxt = (idx == 5'd19) ? LATCH : SUM;
            LATCH:   state_nxt = SEND;
            default: state_nxt = fin ? IDLE : SEND;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            idx    <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            sum_q  <= '0;
            csum_q <= '0;
            err    <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= reject;
            done  <= fin;
            if (accept) begin
                src_q <= src_ip;
                dst_q <= dst_ip;
                len_q <= payload_len + 16'd20;
                sum_q <= '0;
            end
            if (state == SUM) sum_q <= sum_nxt;
            if (state == LATCH) csum_q <= ~sum_q;
            if (accept || state == LATCH) idx <= '0;
            else if ((state == SUM || xfer) && idx != 5'd19) idx <= idx + 5'd1;
        end
    end
`ifdef IPV4_HDR_IDENT_INC_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ident <= '0;
        else if (fin) ident <= ident + 16'd1;
    end
`else
    assign ident = 16'h0000;
`endif
endmodule

// File: tb/tb_ipv4_header_gen.sv
// tb_ipv4_header_gen: table-driven and randomized checks of ipv4_header_gen against an arithmetic header model.
module tb_ipv4_header_gen;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, outready = 1'b0;
    logic [31:0] src_ip = '0, dst_ip = '0;
    logic [15:0] payload_len = '0;
    logic busy, err, outclk, done;
    logic [7:0] out;
    int n_cmp = 0, n_bad = 0;
    logic [15:0] exp_ident = '0;

    ipv4_header_gen dut (.clk(clk), .rst(rst), .start(start), .src_ip(src_ip), .dst_ip(dst_ip),
        .payload_len(payload_len), .busy(busy), .err(err), .out(out), .outclk(outclk),
        .outready(outready), .done(done));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s, d;
        logic [15:0] l;
        int          mode;
        logic        use_c;
        logic [159:0] exp;
    } vec_t;
    vec_t tv[4];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] model(input logic [31:0] s, d, input logic [15:0] l, input logic [15:0] id);
        logic [159:0] h;
        int sum;
        logic [15:0] c, t;
        t = l + 16'd20;
        h = {16'h4500, t, id, 16'h4000, 16'h4011, 16'h0000, s, d};
        sum = 0;
        for (int i = 0; i < 10; i++) sum += int'(h[159 - 16*i -: 16]);
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >>> 16);
        c = ~sum[15:0];
        return {16'h4500, t, id, 16'h4000, 16'h4011, c, s, d};
    endfunction

    task automatic run_pkt(input logic [31:0] s, d, input logic [15:0] l, input int mode,
                           input int ign1, ign2, rst_k, output logic [159:0] got,
                           output int n, output int first_k, output int last_k, output int done_k);
        logic [7:0] held;
        logic stalled;
        @(posedge clk); #1;
        src_ip = s; dst_ip = d; payload_len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; first_k = 0; last_k = 0; done_k = 0; stalled = 1'b0; got = '0; held = '0;
        for (int k = 1; k <= 400 && done_k == 0; k++) begin
            outready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 1) : 1'($urandom_range(0, 1));
            start = (k == ign1 || k == ign2);
            if (k == rst_k) begin
                chk("rst_at_idx7", 160'(n), 160'd7);
                #1 rst = 1'b0;
                #1 chk("rst_outputs", {out, outclk, busy, done, err}, '0);
                @(negedge clk);
                rst = 1'b1; start = 1'b0;
                return;
            end
            @(negedge clk);
            if (k == 1) chk("busy_rise", 160'(busy), 160'd1);
            chk("no_err", 160'(err), 160'd0);
            if (stalled) chk("stall_hold", {outclk, out}, {1'b1, held});
            stalled = outclk && !outready;
            held = out;
            if (outclk && outready) begin
                if (n == 0) first_k = k;
                if (n < 20) got[159 - 8*n -: 8] = out;
                last_k = k;
                n++;
            end
            if (done) begin
                done_k = k;
                chk("busy_drop", 160'(busy), 160'd0);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_pulse_once", 160'(done), 160'd0);
    endtask

    task automatic check_pkt(input string name, input logic [31:0] s, d, input logic [15:0] l,
                             input int mode, input logic use_c, input logic [159:0] cexp);
        logic [159:0] got;
        int n, fk, lk, dk;
        run_pkt(s, d, l, mode, 0, 0, 0, got, n, fk, lk, dk);
        chk({name, "_bytes"}, got, use_c ? cexp : model(s, d, l, exp_ident));
        chk({name, "_count"}, 160'(n), 160'd20);
        chk({name, "_done_after_last"}, 160'(dk), 160'(lk + 1));
        if (mode == 0) begin
            chk({name, "_first_T22"}, 160'(fk), 160'd22);
            chk({name, "_done_T42"}, 160'(dk), 160'd42);
        end
`ifdef IPV4_HDR_IDENT_INC_EN
        if (dk != 0) exp_ident++;
`endif
    endtask

    initial begin
        logic [159:0] got;
        int n, fk, lk, dk, bad;
        tv[0] = '{32'hC0A80001, 32'hC0A800C7, 16'd95, 0, 1'b1,
                  160'h4500_0073_0000_4000_4011_B861_C0A80001_C0A800C7};
`ifdef IPV4_HDR_IDENT_INC_EN
        tv[1] = '{32'hC0A80001, 32'hC0A800C7, 16'd95, 1, 1'b1,
                  160'h4500_0073_0001_4000_4011_B860_C0A80001_C0A800C7};
`else
        tv[1] = '{32'hC0A80001, 32'hC0A800C7, 16'd95, 1, 1'b1,
                  160'h4500_0073_0000_4000_4011_B861_C0A80001_C0A800C7};
`endif
        tv[2] = '{32'h0A000001, 32'h0A000002, 16'd65515, 0, 1'b0, '0};
        tv[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 16'd0, 2, 1'b0, '0};

        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", {busy, err, out, outclk, done}, '0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 4; i++) check_pkt($sformatf("vec%0d", i), tv[i].s, tv[i].d, tv[i].l,
                                              tv[i].mode, tv[i].use_c, tv[i].exp);

        // oversize request is rejected without starting a header
        @(posedge clk); #1;
        payload_len = 16'd65516; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("reject_err", {err, busy}, 160'b10);
        @(negedge clk);
        chk("reject_err_pulse", 160'(err), 160'd0);
        bad = 0;
        repeat (25) begin @(negedge clk); bad += int'(outclk | busy); end
        chk("reject_idle", 160'(bad), 160'd0);

        // starts during an active packet are ignored
        run_pkt(32'hC0A80001, 32'hC0A800C7, 16'd95, 0, 5, 30, 0, got, n, fk, lk, dk);
        chk("ignore_bytes", got, model(32'hC0A80001, 32'hC0A800C7, 16'd95, exp_ident));
        chk("ignore_count", 160'(n), 160'd20);
`ifdef IPV4_HDR_IDENT_INC_EN
        exp_ident++;
`endif
        bad = 0;
        repeat (30) begin @(negedge clk); bad += int'(outclk | busy | err); end
        chk("ignore_quiet", 160'(bad), 160'd0);

        // reset while byte 7 is on the bus, then a clean header
        run_pkt(32'hC0A80001, 32'hC0A800C7, 16'd95, 0, 0, 0, 29, got, n, fk, lk, dk);
        exp_ident = '0;
        check_pkt("after_rst", 32'hC0A80001, 32'hC0A800C7, 16'd95, 0, 1'b1,
                  160'h4500_0073_0000_4000_4011_B861_C0A80001_C0A800C7);

        for (int i = 0; i < 8; i++)
            check_pkt($sformatf("rand%0d", i), $urandom, $urandom,
                      16'($urandom_range(0, 65515)), (i % 3), 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
